control_sequencer: RTL and testbench

- Hardwired control unit directly upstream of the `cpu` datapath. It generates every bus-select, register-load, ALU-op and memory strobe that the datapath consumes each clock.
- Runs fetch (T0–T2), then decode/execute (T3–T6) for register-register ALU, two-operand, MUL/DIV, NOP and HALT instructions.
- Replaces hand-driven control stimulus. The datapath plus this block forms a free-running processor core.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/reg_field_decode.sv | 25 ++
 rtl/control_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu datapath and its hardwired control sequencer:
// sizing defaults, IR field positions, opcode values, state encoding and
// opcode-class helpers.
package cpu_pkg;

    localparam int unsigned REG_COUNT_DEF = 16;
    localparam int unsigned OP_W_DEF      = 5;
    localparam int unsigned REG_IDX_W     = 4;
    localparam int unsigned STATE_W       = 4;

    // IR field bit positions
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    // Opcodes
    localparam logic [OP_W_DEF-1:0] OP_ADD  = 5'd3;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 5'd4;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 5'd5;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 5'd6;
    localparam logic [OP_W_DEF-1:0] OP_ROR  = 5'd7;
    localparam logic [OP_W_DEF-1:0] OP_ROL  = 5'd8;
    localparam logic [OP_W_DEF-1:0] OP_SHR  = 5'd9;
    localparam logic [OP_W_DEF-1:0] OP_SHRA = 5'd10;
    localparam logic [OP_W_DEF-1:0] OP_SHL  = 5'd11;
    localparam logic [OP_W_DEF-1:0] OP_MUL  = 5'd15;
    localparam logic [OP_W_DEF-1:0] OP_DIV  = 5'd16;
    localparam logic [OP_W_DEF-1:0] OP_NEG  = 5'd17;
    localparam logic [OP_W_DEF-1:0] OP_NOT  = 5'd18;
    localparam logic [OP_W_DEF-1:0] OP_NOP  = 5'd26;
    localparam logic [OP_W_DEF-1:0] OP_HALT = 5'd27;

    // Sequencer states; values are visible on the state output
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    // Three-register ALU ops: ra <= rb op rc
    function automatic logic is_alu3(input logic [OP_W_DEF-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    // Two-result ops writing LO/HI
    function automatic logic is_muldiv(input logic [OP_W_DEF-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Single-operand ops: ra <= op rb
    function automatic logic is_unary(input logic [OP_W_DEF-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/reg_field_decode.sv
// Register-index decoder: turns a 4-bit register field plus enable into a
// one-hot register select vector.
//   idx_i    : register index
//   en_i     : select enable; vector is all-zero when low
//   onehot_o : one-hot select, REG_COUNT wide
module reg_field_decode
    import cpu_pkg::*;
#(
    parameter int unsigned REG_COUNT = REG_COUNT_DEF,
    parameter int unsigned IDX_W     = REG_IDX_W
) (
    input  logic [IDX_W-1:0]     idx_i,
    input  logic                 en_i,
    output logic [REG_COUNT-1:0] onehot_o
);

    // One-hot decode gated by enable
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the cpu datapath. Fetch runs T0-T2, then
// decode/execute in T3-T6. All control outputs are Moore decodes of the
// registered state and the IR; nothing depends combinationally on mem_rdy.
//   clk, rst_n        : clock, async active-low reset
//   run               : start request, honoured only in IDLE
//   ir                : current IR (op, ra, rb, rc fields)
//   mem_rdy           : memory read data valid, sampled in T1
//   pc_*/mar/mdr/ir/y/z/lo/hi strobes : datapath control
//   reg_in / reg_out  : one-hot register load / bus drive
//   alu_op            : ALU operation, 0 when idle
//   state, halted     : current state, HALT indicator
//   illegal           : sticky undefined-opcode flag
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned REG_COUNT = REG_COUNT_DEF,
    parameter int unsigned OP_W      = OP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [31:0]          ir,
    input  logic                 mem_rdy,
    output logic                 pc_out,
    output logic                 pc_in,
    output logic                 inc_pc,
    output logic                 mar_in,
    output logic                 mdr_read,
    output logic                 mdr_in,
    output logic                 mdr_out,
    output logic                 ir_in,
    output logic                 y_in,
    output logic                 zlo_in,
    output logic                 zhi_in,
    output logic                 zlo_out,
    output logic                 zhi_out,
    output logic                 lo_in,
    output logic                 hi_in,
    output logic [REG_COUNT-1:0] reg_in,
    output logic [REG_COUNT-1:0] reg_out,
    output logic [OP_W-1:0]      alu_op,
    output logic [STATE_W-1:0]   state,
    output logic                 halted,
    output logic                 illegal
);

    state_e                 state_q, state_d;
    logic                   t1_wait_q, t1_wait_d;
    logic                   illegal_q, illegal_d;

    logic [OP_W_DEF-1:0]    op;
    logic [REG_IDX_W-1:0]   ra, rb, rc;
    logic                   rin_en, rout_en;
    logic [REG_IDX_W-1:0]   rin_idx, rout_idx;
    logic                   unused_ir_bits;

    assign op             = ir[OP_MSB:OP_LSB];
    assign ra             = ir[RA_MSB:RA_LSB];
    assign rb             = ir[RB_MSB:RB_LSB];
    assign rc             = ir[RC_MSB:RC_LSB];
    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    assign state   = state_q;
    assign illegal = illegal_q;

    // State, T1 wait tracking and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            t1_wait_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d   = state_q;
        t1_wait_d = 1'b0;
        illegal_d = illegal_q;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        mar_in    = 1'b0;
        mdr_read  = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        zlo_in    = 1'b0;
        zhi_in    = 1'b0;
        zlo_out   = 1'b0;
        zhi_out   = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        halted    = 1'b0;
        alu_op    = '0;
        rin_en    = 1'b0;
        rin_idx   = ra;
        rout_en   = 1'b0;
        rout_idx  = rb;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                zlo_in  = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                mdr_read = 1'b1;
                mdr_in   = 1'b1;
                // Incremented PC is written back only on the first T1 cycle
                if (!t1_wait_q) begin
                    zlo_out = 1'b1;
                    pc_in   = 1'b1;
                end
                if (mem_rdy) begin
                    state_d = S_T2;
                end else begin
                    t1_wait_d = 1'b1;
                end
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu3(op)) begin
                    rout_en  = 1'b1;
                    rout_idx = rb;
                    y_in     = 1'b1;
                    state_d  = S_T4;
                end else if (is_muldiv(op)) begin
                    rout_en  = 1'b1;
                    rout_idx = ra;
                    y_in     = 1'b1;
                    state_d  = S_T4;
                end else if (is_unary(op)) begin
                    rout_en  = 1'b1;
                    rout_idx = rb;
                    alu_op   = OP_W'(op);
                    zlo_in   = 1'b1;
                    state_d  = S_T4;
                end else if (op == OP_NOP) begin
                    state_d = S_T0;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_T4: begin
                if (is_alu3(op)) begin
                    rout_en  = 1'b1;
                    rout_idx = rc;
                    alu_op   = OP_W'(op);
                    zlo_in   = 1'b1;
                    state_d  = S_T5;
                end else if (is_muldiv(op)) begin
                    rout_en  = 1'b1;
                    rout_idx = rb;
                    alu_op   = OP_W'(op);
                    zlo_in   = 1'b1;
                    zhi_in   = 1'b1;
                    state_d  = S_T5;
                end else if (is_unary(op)) begin
                    zlo_out = 1'b1;
                    rin_en  = 1'b1;
                    rin_idx = ra;
                    state_d = S_T0;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T5: begin
                if (is_alu3(op)) begin
                    zlo_out = 1'b1;
                    rin_en  = 1'b1;
                    rin_idx = ra;
                    state_d = S_T0;
                end else if (is_muldiv(op)) begin
                    zlo_out = 1'b1;
                    lo_in   = 1'b1;
                    state_d = S_T6;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                state_d = S_T0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    reg_field_decode #(
        .REG_COUNT (REG_COUNT),
        .IDX_W     (REG_IDX_W)
    ) u_reg_in_dec (
        .idx_i    (rin_idx),
        .en_i     (rin_en),
        .onehot_o (reg_in)
    );

    reg_field_decode #(
        .REG_COUNT (REG_COUNT),
        .IDX_W     (REG_IDX_W)
    ) u_reg_out_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (reg_out)
    );

    // Only one source may drive the internal bus in any cycle
    a_single_driver: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({pc_out, mdr_out, zlo_out, zhi_out, reg_out}));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed fetch/execute, memory
// wait, MUL, HALT, illegal and async-reset scenarios plus a random program,
// each cycle compared against a per-instruction control schedule.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_read, mdr_in, mdr_out, ir_in;
    logic        y_in, zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_op;
    logic [3:0]  state;
    logic        halted, illegal;

    int   checks = 0;
    int   errors = 0;
    logic exp_ill;

    localparam logic [15:0] B_PC_OUT   = 16'h8000;
    localparam logic [15:0] B_PC_IN    = 16'h4000;
    localparam logic [15:0] B_INC_PC   = 16'h2000;
    localparam logic [15:0] B_MAR_IN   = 16'h1000;
    localparam logic [15:0] B_MDR_READ = 16'h0800;
    localparam logic [15:0] B_MDR_IN   = 16'h0400;
    localparam logic [15:0] B_MDR_OUT  = 16'h0200;
    localparam logic [15:0] B_IR_IN    = 16'h0100;
    localparam logic [15:0] B_Y_IN     = 16'h0080;
    localparam logic [15:0] B_ZLO_IN   = 16'h0040;
    localparam logic [15:0] B_ZHI_IN   = 16'h0020;
    localparam logic [15:0] B_ZLO_OUT  = 16'h0010;
    localparam logic [15:0] B_ZHI_OUT  = 16'h0008;
    localparam logic [15:0] B_LO_IN    = 16'h0004;
    localparam logic [15:0] B_HI_IN    = 16'h0002;
    localparam logic [15:0] B_HALTED   = 16'h0001;

    logic [4:0] legal_ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                   5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd26};
    logic [4:0] bad_ops [17]   = '{5'd0, 5'd1, 5'd2, 5'd12, 5'd13, 5'd14, 5'd19, 5'd20,
                                   5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd28, 5'd29,
                                   5'd30, 5'd31};

    logic [57:0] obs;
    assign obs = {state, alu_op, reg_in, reg_out,
                  {pc_out, pc_in, inc_pc, mar_in, mdr_read, mdr_in, mdr_out, ir_in,
                   y_in, zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in, halted},
                  illegal};

    control_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .ir       (ir),
        .mem_rdy  (mem_rdy),
        .pc_out   (pc_out),
        .pc_in    (pc_in),
        .inc_pc   (inc_pc),
        .mar_in   (mar_in),
        .mdr_read (mdr_read),
        .mdr_in   (mdr_in),
        .mdr_out  (mdr_out),
        .ir_in    (ir_in),
        .y_in     (y_in),
        .zlo_in   (zlo_in),
        .zhi_in   (zhi_in),
        .zlo_out  (zlo_out),
        .zhi_out  (zhi_out),
        .lo_in    (lo_in),
        .hi_in    (hi_in),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .alu_op   (alu_op),
        .state    (state),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] one;
        one = 16'd1;
        return one << i;
    endfunction

    // Expected output word in the same layout as obs
    function automatic logic [57:0] word(input logic [3:0] st, input logic [15:0] sb,
                                         input logic [15:0] rin, input logic [15:0] rout,
                                         input logic [4:0] alu, input logic ill);
        return {st, alu, rin, rout, sb, ill};
    endfunction

    task automatic check(input string tag, input logic [57:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then set inputs for the closing edge
    task automatic cyc(input string tag, input logic [57:0] exp, input logic mem);
        @(negedge clk);
        check(tag, exp);
        mem_rdy = mem;
        run     = 1'($urandom);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        run     = 1'b0;
        exp_ill = 1'b0;
        #1 check(tag, word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check({tag, "_idle"}, word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
    endtask

    // Fetch + execute one instruction from the T0 cycle; stop_at=4 returns after T4
    task automatic instr(input logic [31:0] iw, input int waits, input int stop_at);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = iw[31:27];
        ra = iw[26:23];
        rb = iw[22:19];
        rc = iw[18:15];
        cyc("T0", word(4'd1, B_PC_OUT | B_MAR_IN | B_INC_PC | B_ZLO_IN, 16'h0, 16'h0, 5'd0, exp_ill),
            1'($urandom));
        ir = iw;
        for (int k = 0; k <= waits; k++) begin
            if (k == 0)
                cyc("T1", word(4'd2, B_ZLO_OUT | B_PC_IN | B_MDR_READ | B_MDR_IN,
                               16'h0, 16'h0, 5'd0, exp_ill), k == waits);
            else
                cyc("T1_wait", word(4'd2, B_MDR_READ | B_MDR_IN, 16'h0, 16'h0, 5'd0, exp_ill),
                    k == waits);
        end
        cyc("T2", word(4'd3, B_MDR_OUT | B_IR_IN, 16'h0, 16'h0, 5'd0, exp_ill), 1'($urandom));
        if (op >= 5'd3 && op <= 5'd11) begin
            cyc("alu_T3", word(4'd4, B_Y_IN, 16'h0, oh(rb), 5'd0, exp_ill), 1'($urandom));
            cyc("alu_T4", word(4'd5, B_ZLO_IN, 16'h0, oh(rc), op, exp_ill), 1'($urandom));
            if (stop_at == 4) return;
            cyc("alu_T5", word(4'd6, B_ZLO_OUT, oh(ra), 16'h0, 5'd0, exp_ill), 1'($urandom));
        end else if (op == 5'd15 || op == 5'd16) begin
            cyc("md_T3", word(4'd4, B_Y_IN, 16'h0, oh(ra), 5'd0, exp_ill), 1'($urandom));
            cyc("md_T4", word(4'd5, B_ZLO_IN | B_ZHI_IN, 16'h0, oh(rb), op, exp_ill), 1'($urandom));
            cyc("md_T5", word(4'd6, B_ZLO_OUT | B_LO_IN, 16'h0, 16'h0, 5'd0, exp_ill), 1'($urandom));
            cyc("md_T6", word(4'd7, B_ZHI_OUT | B_HI_IN, 16'h0, 16'h0, 5'd0, exp_ill), 1'($urandom));
        end else if (op == 5'd17 || op == 5'd18) begin
            cyc("un_T3", word(4'd4, B_ZLO_IN, 16'h0, oh(rb), op, exp_ill), 1'($urandom));
            cyc("un_T4", word(4'd5, B_ZLO_OUT, oh(ra), 16'h0, 5'd0, exp_ill), 1'($urandom));
        end else if (op == 5'd26) begin
            cyc("nop_T3", word(4'd4, 16'h0, 16'h0, 16'h0, 5'd0, exp_ill), 1'($urandom));
        end else begin
            cyc("stop_T3", word(4'd4, 16'h0, 16'h0, 16'h0, 5'd0, exp_ill), 1'($urandom));
            if (op != 5'd27) exp_ill = 1'b1;
            for (int h = 0; h < 4; h++)
                cyc("halt", word(4'd8, B_HALTED, 16'h0, 16'h0, 5'd0, exp_ill), 1'($urandom));
        end
    endtask

    initial begin
        logic [31:0] iw;
        rst_n   = 1'b0;
        run     = 1'b0;
        mem_rdy = 1'b0;
        ir      = 32'h0;
        exp_ill = 1'b0;

        #12 check("reset", word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle", word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        end

        // Directed: AND, AND with 3 wait cycles, MUL
        run = 1'b1;
        instr(32'h28918000, 0, 0);
        instr(32'h28918000, 3, 0);
        instr(32'h78900000, 1, 0);

        // Random program of legal, non-stopping instructions
        for (int n = 0; n < 24; n++) begin
            iw = {legal_ops[$urandom_range(0, 14)], 4'($urandom), 4'($urandom),
                  4'($urandom), 15'($urandom)};
            instr(iw, $urandom_range(0, 3), 0);
        end

        // HALT: halted, illegal stays low
        instr({5'd27, 27'($urandom)}, 1, 0);
        pulse_reset("rst_after_halt");

        // Illegal opcodes: op 31, then a random undefined one
        for (int j = 0; j < 2; j++) begin
            run = 1'b1;
            iw  = {(j == 0) ? 5'd31 : bad_ops[$urandom_range(0, 16)], 27'($urandom)};
            instr(iw, $urandom_range(0, 2), 0);
            pulse_reset("rst_after_illegal");
        end

        // Async reset in T4 of an ADD
        run = 1'b1;
        instr({5'd3, 4'd7, 4'd9, 4'd12, 15'h0}, 0, 4);
        #2 rst_n = 1'b0;
        run = 1'b0;
        #1 check("async_rst", word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("in_rst", word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst", word(4'd0, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
